alu_writeback: RTL

//  Execute-to-writeback stage directly downstream of the 8-bit ALU.
//  - Buffers each ALU result (out, {C,N,Z} flags, dest reg, enables) in a small in-order FIFO.
//  - Drains entries into the register-file write port.
//  - Commits architectural flags in program order.
//  - Returns the committed carry to the ALU cin input.
//  - Evaluates a branch condition against the committed flags.

---
 rtl/alu_writeback.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: in-order result FIFO, register-file drain, and flag commit.
// Optional feature: define ALU_WB_FLAG_FWD_EN to forward pending flags to carry_q/cond_true.
module alu_writeback #(
  parameter int DEPTH   = 2,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_result,
  input  logic [2:0]         in_flags,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_wen,
  input  logic               in_fen,
  output logic               wr_en,
  output logic [RADDR_W-1:0] wr_addr,
  output logic [7:0]         wr_data,
  input  logic               wr_ready,
  output logic [2:0]         flags_q,
  output logic               carry_q,
  input  logic [1:0]         cond_sel,
  output logic               cond_true
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fifo_state_t;

  fifo_state_t        state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic               alive_q;
  logic [RADDR_W-1:0] last_addr_q;
  logic [7:0]         last_data_q;

  logic [7:0]         res_mem   [DEPTH];
  logic [2:0]         flags_mem [DEPTH];
  logic [RADDR_W-1:0] rd_mem    [DEPTH];
  logic               wen_mem   [DEPTH];
  logic               fen_mem   [DEPTH];

  logic       head_valid;
  logic       push;
  logic       pop;
  logic [2:0] eff_flags;

  // in_ready depends only on registered state; alive_q holds it low until the first edge after reset.
  assign head_valid = (state_q != EMPTY);
  assign in_ready   = alive_q && (state_q != FULL);
  assign push       = in_valid && in_ready;
  assign pop        = head_valid && (wr_ready || !wen_mem[head_q]);

  assign wr_en   = head_valid && wen_mem[head_q];
  assign wr_addr = head_valid ? rd_mem[head_q]  : last_addr_q;
  assign wr_data = head_valid ? res_mem[head_q] : last_data_q;

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (count_d == '0) begin
      state_d = EMPTY;
    end else if (count_d == CNT_W'(DEPTH)) begin
      state_d = FULL;
    end else begin
      state_d = PARTIAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      alive_q     <= 1'b0;
      flags_q     <= 3'b000;
      last_addr_q <= '0;
      last_data_q <= 8'h00;
    end else begin
      alive_q <= 1'b1;
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
        if (fen_mem[head_q]) begin
          flags_q <= flags_mem[head_q];
        end
      end
      if (head_valid) begin
        last_addr_q <= rd_mem[head_q];
        last_data_q <= res_mem[head_q];
      end
    end
  end

  // Payload needs no reset: entries are only observed while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[tail_q]   <= in_result;
      flags_mem[tail_q] <= in_flags;
      rd_mem[tail_q]    <= in_rd;
      wen_mem[tail_q]   <= in_wen && (in_rd != '0);
      fen_mem[tail_q]   <= in_fen;
    end
  end

`ifdef ALU_WB_FLAG_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so the youngest pending flag-writer wins.
  always_comb begin
    eff_flags = flags_q;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((i < int'(count_q)) && fen_mem[fwd_idx]) begin
        eff_flags = flags_mem[fwd_idx];
      end
    end
  end
`else
  assign eff_flags = flags_q;
`endif

  assign carry_q = eff_flags[2];

  always_comb begin
    cond_true = 1'b1;
    case (cond_sel)
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = eff_flags[0];
      2'b10:   cond_true = eff_flags[1];
      default: cond_true = eff_flags[2];
    endcase
  end

endmodule
